// File: rtl/bcd_to_bin_seq.sv
// rtl/bcd_to_bin_seq.sv - iterative packed-BCD to binary converter, one digit per clock
module bcd_to_bin_seq #(
    parameter int DIGITS = 4,
    parameter int OUT_W  = 14
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic [OUT_W-1:0]      bin_out,
    output logic                  err,
    output logic                  ovf
);

    localparam int ACC_W = OUT_W + 4;
    localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIGITS - 1);

    typedef enum logic {
        S_IDLE,
        S_CONV
    } state_t;

    state_t              r_state;
    logic [4*DIGITS-1:0] r_shift;
    logic [ACC_W-1:0]    r_acc;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_err_i;
    logic                r_ovf_i;

    logic [3:0]          w_digit;
    logic [ACC_W-1:0]    w_acc_next;
    logic                w_err_next;
    logic                w_ovf_next;

    // Four spare bits keep acc*10+15 from wrapping while acc < 2^OUT_W,
    // so the sticky overflow flag catches the first crossing.
    assign w_digit    = r_shift[4*DIGITS-1 -: 4];
    assign w_acc_next = r_acc * ACC_W'(10) + {{(ACC_W-4){1'b0}}, w_digit};
    assign w_err_next = r_err_i | (w_digit > 4'd9);
    assign w_ovf_next = r_ovf_i | (|w_acc_next[ACC_W-1:OUT_W]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_shift <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_err_i <= 1'b0;
            r_ovf_i <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            bin_out <= '0;
            err     <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_shift <= bcd_in;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_err_i <= 1'b0;
                        r_ovf_i <= 1'b0;
                        busy    <= 1'b1;
                        r_state <= S_CONV;
                    end
                end
                S_CONV: begin
                    r_acc   <= w_acc_next;
                    r_shift <= r_shift << 4;
                    r_cnt   <= r_cnt + 1'b1;
                    r_err_i <= w_err_next;
                    r_ovf_i <= w_ovf_next;
                    if (r_cnt == LAST_CNT) begin
                        bin_out <= w_acc_next[OUT_W-1:0];
                        err     <= w_err_next;
                        ovf     <= w_ovf_next;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
